lsu_bus_ctrl: RTL and testbench

Sequential load/store controller between the core's memory stage and the data bus. It accepts one load or store per request and validates size and alignment. It drives a valid/grant bus transaction with lane byte-enables and lane-replicated store data. Load data is sign- or zero-extended back to 32 bits, and the core is stalled until the access completes, faults, or times out.

---
 rtl/lsu_bus_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: validates one core memory request, runs a
// single valid/grant bus transaction and returns extended load data or a fault.
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    // ---------------------------------------------------------------
    // Request decode (evaluated on the incoming, not yet latched, request)
    // ---------------------------------------------------------------
    logic        size_legal;
    logic        misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;

    always_comb begin
        size_legal = 1'b0;
        case (req_size)
            SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
            SZ_BU, SZ_HU:     size_legal = !req_write;
            default:          size_legal = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (req_size[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be_in    = 4'b1111;
        wdata_in = req_wdata;
        case (req_size[1:0])
            2'b00: begin
                be_in    = 4'b0001 << req_addr[1:0];
                wdata_in = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_in    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{req_wdata[15:0]}};
            end
            default: begin
                be_in    = 4'b1111;
                wdata_in = req_wdata;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Load lane selection and extension from the latched address/size
    // ---------------------------------------------------------------
    logic [7:0]  rd_byte [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = rd_byte[addr_q[1:0]];
    assign ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        ld_ext = bus_rdata;
        case (size_q)
            SZ_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            SZ_BU:   ld_ext = {24'h0, ld_byte};
            SZ_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            SZ_HU:   ld_ext = {16'h0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        cause_d = cause_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!size_legal) begin
                        state_d = DONE;
                        rdata_d = 32'h0;
                        fault_d = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = DONE;
                        rdata_d = 32'h0;
                        fault_d = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 16'h0;
                        we_d    = req_write;
                        addr_d  = req_addr;
                        size_d  = req_size;
                        be_d    = be_in;
                        wdata_d = wdata_in;
                    end
                end
            end

            REQ: begin
                // A grant on the last allowed cycle still wins over the timeout.
                if (bus_gnt) begin
                    cnt_d = 16'h0;
                    if (we_q) begin
                        state_d = DONE;
                        rdata_d = 32'h0;
                        fault_d = 1'b0;
                        cause_d = CAUSE_NONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    rdata_d = 32'h0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end

            WAIT: begin
                if (bus_rvalid) begin
                    state_d = DONE;
                    rdata_d = ld_ext;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    rdata_d = 32'h0;
                    fault_d = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'h0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            size_q  <= 3'b000;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs: bus fields are forced to zero outside the request phase
    // ---------------------------------------------------------------
    assign bus_req     = (state_q == REQ);
    assign bus_we      = bus_req & we_q;
    assign bus_addr    = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be      = bus_req ? be_q : 4'h0;
    assign bus_wdata   = bus_req ? wdata_q : 32'h0;

    assign done        = (state_q == DONE);
    assign stall       = req_valid && (state_q != DONE);
    assign rdata       = rdata_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: a vector table of bus scenarios with a result
// scoreboard, plus hand sequences for reset behaviour.
module tb_lsu_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .done        (done),
        .rdata       (rdata),
        .fault       (fault),
        .fault_cause (fault_cause),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rd;
        int          gnt_dly;     // REQ cycle index that sees gnt (>=255: never)
        int          rv_dly;      // WAIT cycle index that sees rvalid (>=255: never)
        logic        rv_gnt;      // also pulse a bogus rvalid with the grant
        logic [3:0]  exp_be;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [1:0]  exp_cause;
        int          exp_stalls;
        int          exp_reqcyc;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] brd, input int gd,
                           input int rd, input logic rg, input logic [3:0] be,
                           input logic [31:0] ba, input logic [31:0] bwd, input logic [31:0] er,
                           input logic ef, input logic [1:0] ec, input int es, input int erq);
        vec_t v;
        v.write = w; v.size = sz; v.addr = a; v.wdata = wd; v.bus_rd = brd;
        v.gnt_dly = gd; v.rv_dly = rd; v.rv_gnt = rg; v.exp_be = be;
        v.exp_baddr = ba; v.exp_bwdata = bwd; v.exp_rdata = er;
        v.exp_fault = ef; v.exp_cause = ec; v.exp_stalls = es; v.exp_reqcyc = erq;
        tbl.push_back(v);
    endtask

    // Drive one request starting at negedge+1, act as the bus slave, and check on done.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        int   stalls   = 0;
        int   req_cyc  = 0;
        int   wait_cyc = 0;
        bit   granted  = 0;
        bit   finished = 0;

        req_write = v.write;
        req_size  = v.size;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        e.rdata = v.exp_rdata;
        e.fault = v.exp_fault;
        e.cause = v.exp_cause;
        sb.push_back(e);
        #1;

        for (int cyc = 0; cyc < 64; cyc++) begin
            if (done) begin
                finished = 1;
                break;
            end
            if (cyc == 1) begin
                // Request fields change after acceptance; the bus must not follow them.
                req_addr  = ~v.addr;
                req_wdata = ~v.wdata;
                #1;
            end
            if (stall) stalls++;
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_rdata  = 32'h0;
            if (bus_req) begin
                if (req_cyc == 0) begin
                    chk($sformatf("v%0d_bus_be", idx), {28'h0, bus_be}, {28'h0, v.exp_be});
                    chk($sformatf("v%0d_bus_addr", idx), bus_addr, v.exp_baddr);
                    chk($sformatf("v%0d_bus_we", idx), {31'h0, bus_we}, {31'h0, v.write});
                    if (v.write)
                        chk($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.exp_bwdata);
                end
                if (req_cyc == v.gnt_dly) begin
                    bus_gnt = 1'b1;
                    granted = 1;
                    if (v.rv_gnt) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = ~v.bus_rd;
                    end
                end
                req_cyc++;
            end else if (granted) begin
                if (wait_cyc == 0)
                    chk($sformatf("v%0d_wait_bus_idle", idx),
                        {bus_wdata[31:5], bus_we, bus_be} | bus_addr | bus_wdata, 32'h0);
                if (wait_cyc == v.rv_dly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = v.bus_rd;
                end
                wait_cyc++;
            end
            @(negedge clk);
            #1;
        end

        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d_done_timeout: got no done expected done within 64 cycles", idx);
            req_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end

        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d_scoreboard: got empty queue expected an entry", idx);
        end else begin
            got = sb.pop_front();
            chk($sformatf("v%0d_rdata", idx), rdata, got.rdata);
            chk($sformatf("v%0d_fault", idx), {31'h0, fault}, {31'h0, got.fault});
            chk($sformatf("v%0d_cause", idx), {30'h0, fault_cause}, {30'h0, got.cause});
        end
        chk($sformatf("v%0d_stalls", idx), stalls, v.exp_stalls);
        chk($sformatf("v%0d_req_cycles", idx), req_cyc, v.exp_reqcyc);
        chk($sformatf("v%0d_stall_in_done", idx), {31'h0, stall}, 32'h0);
        $display("vec %0d: we=%0b size=%03b addr=%08h -> rdata=%08h fault=%0b cause=%02b stalls=%0d req_cycles=%0d",
                 idx, v.write, v.size, v.addr, rdata, fault, fault_cause, stalls, req_cyc);

        req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_done_one_cycle", idx), {31'h0, done}, 32'h0);
    endtask

    initial begin
        vec_t fresh;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'h0;

        //       we  size    addr          wdata         bus_rdata     gd   rd   rg  be       baddr         bwdata        rdata         f  cause  st rq
        add_vec(0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,   0,   0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 0, 2'b00, 3, 1);
        add_vec(0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_0000, 0,   0,   0, 4'b1100, 32'h0000_2000, 32'h0,        32'h0000_8001, 0, 2'b00, 3, 1);
        add_vec(0, 3'b010, 32'h0000_2000, 32'h0,        32'h8001_0000, 0,   0,   0, 4'b1111, 32'h0000_2000, 32'h0,        32'h8001_0000, 0, 2'b00, 3, 1);
        add_vec(1, 3'b000, 32'h0000_0010, 32'h0000_00AB, 32'h0,        2,   0,   0, 4'b0001, 32'h0000_0010, 32'hABAB_ABAB, 32'h0,        0, 2'b00, 4, 3);
        add_vec(0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b01, 1, 0);
        add_vec(0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b10, 1, 0);
        add_vec(1, 3'b100, 32'h0000_0000, 32'h5555_5555, 32'h0,        0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b10, 1, 0);
        add_vec(0, 3'b111, 32'h0000_0001, 32'h0,        32'h0,         0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b10, 1, 0);
        add_vec(0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,         0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b10, 1, 0);
        add_vec(0, 3'b101, 32'h0000_2001, 32'h0,        32'h0,         0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b01, 1, 0);
        add_vec(1, 3'b010, 32'h0000_0032, 32'h1111_2222, 32'h0,        0,   0,   0, 4'b0000, 32'h0,         32'h0,        32'h0,         1, 2'b01, 1, 0);
        add_vec(0, 3'b001, 32'h0000_0102, 32'h0,        32'hF00D_7FFF, 0,   0,   0, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF_F00D, 0, 2'b00, 3, 1);
        add_vec(0, 3'b001, 32'h0000_0100, 32'h0,        32'hF00D_7FFF, 0,   0,   0, 4'b0011, 32'h0000_0100, 32'h0,        32'h0000_7FFF, 0, 2'b00, 3, 1);
        add_vec(0, 3'b100, 32'h0000_0041, 32'h0,        32'h0000_9A00, 0,   0,   0, 4'b0010, 32'h0000_0040, 32'h0,        32'h0000_009A, 0, 2'b00, 3, 1);
        add_vec(1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0,        0,   0,   0, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF, 32'h0,        0, 2'b00, 2, 1);
        add_vec(1, 3'b010, 32'h0000_0030, 32'h1234_5678, 32'h0,        3,   0,   0, 4'b1111, 32'h0000_0030, 32'h1234_5678, 32'h0,        0, 2'b00, 5, 4);
        add_vec(0, 3'b000, 32'h0000_0052, 32'h0,        32'h007F_0000, 0,   2,   0, 4'b0100, 32'h0000_0050, 32'h0,        32'h0000_007F, 0, 2'b00, 5, 1);
        add_vec(0, 3'b010, 32'h0000_0040, 32'h0,        32'h0,         255, 0,   0, 4'b1111, 32'h0000_0040, 32'h0,        32'h0,         1, 2'b11, 5, 4);
        add_vec(0, 3'b010, 32'h0000_0044, 32'h0,        32'h1111_1111, 0,   255, 0, 4'b1111, 32'h0000_0044, 32'h0,        32'h0,         1, 2'b11, 6, 1);
        add_vec(0, 3'b010, 32'h0000_0060, 32'h0,        32'hCAFE_F00D, 0,   3,   0, 4'b1111, 32'h0000_0060, 32'h0,        32'hCAFE_F00D, 0, 2'b00, 6, 1);
        add_vec(0, 3'b010, 32'h0000_0070, 32'h0,        32'h0BAD_F00D, 0,   0,   1, 4'b1111, 32'h0000_0070, 32'h0,        32'h0BAD_F00D, 0, 2'b00, 3, 1);

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_done_busreq", {30'h0, done, bus_req}, 32'h0);
        chk("rst_bus_fields", bus_addr | bus_wdata | {27'h0, bus_we, bus_be}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault", {29'h0, fault, fault_cause}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            run_vec(i, tbl[i]);

        // Reset asserted mid-cycle while a load sits in WAIT
        req_write = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h0000_0080;
        req_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("rstw_in_req", {31'h0, bus_req}, 32'h1);
        bus_gnt = 1'b1;
        @(negedge clk);
        #1;
        bus_gnt = 1'b0;
        chk("rstw_in_wait", {31'h0, bus_req}, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("rstw_async_busreq_done", {30'h0, bus_req, done}, 32'h0);
        chk("rstw_async_rdata", rdata, 32'h0);
        chk("rstw_async_fault", {29'h0, fault, fault_cause}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rstw_no_completion", {31'h0, done}, 32'h0);
        $display("reset in WAIT: bus_req=%0b done=%0b rdata=%08h", bus_req, done, rdata);

        fresh.write = 0; fresh.size = 3'b010; fresh.addr = 32'h0000_0084; fresh.wdata = 32'h0;
        fresh.bus_rd = 32'h5A5A_1234; fresh.gnt_dly = 0; fresh.rv_dly = 0; fresh.rv_gnt = 0;
        fresh.exp_be = 4'b1111; fresh.exp_baddr = 32'h0000_0084; fresh.exp_bwdata = 32'h0;
        fresh.exp_rdata = 32'h5A5A_1234; fresh.exp_fault = 0; fresh.exp_cause = 2'b00;
        fresh.exp_stalls = 3; fresh.exp_reqcyc = 1;
        run_vec(100, fresh);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
